// File: rtl/control_pipeline_unit.sv
// Control decode and E/M/W control pipeline for a 5-stage RISC-V core.
// Decodes D-stage fields and carries the control bundle down the pipe.
module control_pipeline_unit #(
    parameter int ALUCTRL_W = 4,
    parameter bit EXT_OPS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 zero_e,
    output logic [1:0]           immsrc_d,
    output logic                 illegal_d,
    output logic                 regwrite_e,
    output logic [1:0]           resultsrc_e,
    output logic                 memwrite_e,
    output logic                 jump_e,
    output logic                 branch_e,
    output logic [ALUCTRL_W-1:0] alucontrol_e,
    output logic                 alusrc_e,
    output logic                 pcsrc_e,
    output logic                 regwrite_m,
    output logic [1:0]           resultsrc_m,
    output logic                 memwrite_m,
    output logic                 regwrite_w,
    output logic [1:0]           resultsrc_w
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;

    typedef struct packed {
        logic                 regwrite;
        logic [1:0]           resultsrc;
        logic                 memwrite;
        logic                 jump;
        logic                 branch;
        logic [ALUCTRL_W-1:0] alucontrol;
        logic                 alusrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
    } wb_ctrl_t;

    ex_ctrl_t  ctrl_d;
    ex_ctrl_t  ex_d, ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d, wb_q;
    logic      stalled_d, stalled_q;
    logic [1:0] aluop;
    logic [1:0] immsrc;
    logic [3:0] alu_code;
    logic       op_ok;
    logic       f3_ok;

    // Main decode plus ALU decode; illegal encodings collapse to a bubble
    always_comb begin
        ctrl_d   = '0;
        immsrc   = 2'b00;
        aluop    = 2'b00;
        op_ok    = 1'b1;
        f3_ok    = 1'b1;
        alu_code = ALU_ADD;
        unique case (op)
            OP_LW: begin
                ctrl_d.regwrite  = 1'b1;
                ctrl_d.alusrc    = 1'b1;
                ctrl_d.resultsrc = 2'b01;
            end
            OP_SW: begin
                immsrc          = 2'b01;
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            OP_R: begin
                ctrl_d.regwrite = 1'b1;
                aluop           = 2'b10;
            end
            OP_I: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.alusrc   = 1'b1;
                aluop           = 2'b10;
            end
            OP_BEQ: begin
                immsrc        = 2'b10;
                ctrl_d.branch = 1'b1;
                aluop         = 2'b01;
            end
            OP_JAL: begin
                ctrl_d.regwrite  = 1'b1;
                immsrc           = 2'b11;
                ctrl_d.resultsrc = 2'b10;
                ctrl_d.jump      = 1'b1;
            end
            default: op_ok = 1'b0;
        endcase
        unique case (aluop)
            2'b01: alu_code = ALU_SUB;
            2'b10: begin
                unique case (funct3)
                    3'b000: alu_code = (op == OP_R && funct7_5)
                                       ? ALU_SUB : ALU_ADD;
                    3'b010: alu_code = ALU_SLT;
                    3'b110: alu_code = ALU_OR;
                    3'b111: alu_code = ALU_AND;
                    3'b100: begin
                        alu_code = ALU_XOR;
                        f3_ok    = EXT_OPS;
                    end
                    3'b001: begin
                        alu_code = ALU_SLL;
                        f3_ok    = EXT_OPS;
                    end
                    3'b101: begin
                        alu_code = funct7_5 ? ALU_SRA : ALU_SRL;
                        f3_ok    = EXT_OPS;
                    end
                    default: f3_ok = 1'b0;
                endcase
            end
            default: alu_code = ALU_ADD;
        endcase
        ctrl_d.alucontrol = ALUCTRL_W'(alu_code);
        illegal_d = ~(op_ok & f3_ok);
        if (illegal_d) begin
            ctrl_d = '0;
            immsrc = 2'b00;
        end
        immsrc_d = immsrc;
    end

    // Next-state for E (flush beats stall), M (bubble after a stall) and W
    always_comb begin
        ex_d = ctrl_d;
        if (flush_e) begin
            ex_d = '0;
        end else if (stall_e) begin
            ex_d = ex_q;
        end
        mem_d = '0;
        if (!stalled_q) begin
            mem_d.regwrite  = ex_q.regwrite;
            mem_d.resultsrc = ex_q.resultsrc;
            mem_d.memwrite  = ex_q.memwrite;
        end
        wb_d.regwrite  = mem_q.regwrite;
        wb_d.resultsrc = mem_q.resultsrc;
        stalled_d      = stall_e;
    end

    // Pipeline control registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stalled_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            stalled_q <= stalled_d;
        end
    end

    assign regwrite_e   = ex_q.regwrite;
    assign resultsrc_e  = ex_q.resultsrc;
    assign memwrite_e   = ex_q.memwrite;
    assign jump_e       = ex_q.jump;
    assign branch_e     = ex_q.branch;
    assign alucontrol_e = ex_q.alucontrol;
    assign alusrc_e     = ex_q.alusrc;
    assign pcsrc_e      = ex_q.jump | (ex_q.branch & zero_e);
    assign regwrite_m   = mem_q.regwrite;
    assign resultsrc_m  = mem_q.resultsrc;
    assign memwrite_m   = mem_q.memwrite;
    assign regwrite_w   = wb_q.regwrite;
    assign resultsrc_w  = wb_q.resultsrc;

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Self-checking bench for control_pipeline_unit.
// Table-driven decode vectors plus directed pipeline sequences.
module tb_control_pipeline_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       stall_e = 1'b0;
    logic       flush_e = 1'b0;
    logic       zero_e = 1'b0;

    logic [1:0] immsrc_d;
    logic       illegal_d;
    logic       regwrite_e;
    logic [1:0] resultsrc_e;
    logic       memwrite_e;
    logic       jump_e;
    logic       branch_e;
    logic [3:0] alucontrol_e;
    logic       alusrc_e;
    logic       pcsrc_e;
    logic       regwrite_m;
    logic [1:0] resultsrc_m;
    logic       memwrite_m;
    logic       regwrite_w;
    logic [1:0] resultsrc_w;

    logic [1:0] b_immsrc_d;
    logic       b_illegal_d;
    logic       b_regwrite_e;
    logic [1:0] b_resultsrc_e;
    logic       b_memwrite_e;
    logic       b_jump_e;
    logic       b_branch_e;
    logic [3:0] b_alucontrol_e;
    logic       b_alusrc_e;
    logic       b_pcsrc_e;
    logic       b_regwrite_m;
    logic [1:0] b_resultsrc_m;
    logic       b_memwrite_m;
    logic       b_regwrite_w;
    logic [1:0] b_resultsrc_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipeline_unit #(.ALUCTRL_W(4), .EXT_OPS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7_5(funct7_5), .stall_e(stall_e), .flush_e(flush_e),
        .zero_e(zero_e), .immsrc_d(immsrc_d), .illegal_d(illegal_d),
        .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e),
        .memwrite_e(memwrite_e), .jump_e(jump_e), .branch_e(branch_e),
        .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e),
        .pcsrc_e(pcsrc_e), .regwrite_m(regwrite_m),
        .resultsrc_m(resultsrc_m), .memwrite_m(memwrite_m),
        .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w)
    );

    control_pipeline_unit #(.ALUCTRL_W(4), .EXT_OPS(1'b0)) dut_base (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7_5(funct7_5), .stall_e(stall_e), .flush_e(flush_e),
        .zero_e(zero_e), .immsrc_d(b_immsrc_d), .illegal_d(b_illegal_d),
        .regwrite_e(b_regwrite_e), .resultsrc_e(b_resultsrc_e),
        .memwrite_e(b_memwrite_e), .jump_e(b_jump_e),
        .branch_e(b_branch_e), .alucontrol_e(b_alucontrol_e),
        .alusrc_e(b_alusrc_e), .pcsrc_e(b_pcsrc_e),
        .regwrite_m(b_regwrite_m), .resultsrc_m(b_resultsrc_m),
        .memwrite_m(b_memwrite_m), .regwrite_w(b_regwrite_w),
        .resultsrc_w(b_resultsrc_w)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
        logic [1:0]  imm;
        logic [10:0] ex;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7);
        op       = o;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    function automatic logic [10:0] ex_bus();
        return {regwrite_e, resultsrc_e, memwrite_e, jump_e, branch_e,
                alucontrol_e, alusrc_e};
    endfunction

    function automatic logic [20:0] all_outs();
        return {ex_bus(), pcsrc_e, regwrite_m, resultsrc_m, memwrite_m,
                regwrite_w, resultsrc_w};
    endfunction

    initial begin
        // {rw, rs[1:0], mw, jump, branch, alu[3:0], alusrc}
        vecs[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 11'b1_01_0_0_0_0000_1};
        vecs[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 11'b0_00_1_0_0_0000_1};
        vecs[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0000_0};
        vecs[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 11'b1_00_0_0_0_0001_0};
        vecs[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0101_0};
        vecs[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0011_0};
        vecs[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0010_0};
        vecs[7]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0100_0};
        vecs[8]  = '{7'b0110011, 3'b001, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0110_0};
        vecs[9]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 2'b00, 11'b1_00_0_0_0_0111_0};
        vecs[10] = '{7'b0110011, 3'b101, 1'b1, 1'b0, 2'b00, 11'b1_00_0_0_0_1000_0};
        vecs[11] = '{7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 11'b1_00_0_0_0_0000_1};
        vecs[12] = '{7'b0010011, 3'b101, 1'b1, 1'b0, 2'b00, 11'b1_00_0_0_0_1000_1};
        vecs[13] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 11'b0_00_0_0_1_0001_0};
        vecs[14] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 11'b1_10_0_1_0_0000_0};
        vecs[15] = '{7'b1111111, 3'b000, 1'b0, 1'b1, 2'b00, 11'b0_00_0_0_0_0000_0};
        vecs[16] = '{7'b0110011, 3'b011, 1'b0, 1'b1, 2'b00, 11'b0_00_0_0_0_0000_0};

        // Reset state
        drive(7'b0000011, 3'b000, 1'b0);
        #1;
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_load_after_reset", 32'(regwrite_e), 32'd1);

        // Decode table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
            #1;
            chk($sformatf("v%0d_illegal_d", i), 32'(illegal_d),
                32'(vecs[i].ill));
            chk($sformatf("v%0d_immsrc_d", i), 32'(immsrc_d),
                32'(vecs[i].imm));
            step();
            chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_bus()),
                32'(vecs[i].ex));
        end

        // Base-ISA build rejects the extended funct3 codes
        drive(7'b0110011, 3'b100, 1'b0);
        #1;
        chk("base_xor_illegal", 32'(b_illegal_d), 32'd1);
        chk("ext_xor_legal", 32'(illegal_d), 32'd0);
        drive(7'b0110011, 3'b110, 1'b0);
        #1;
        chk("base_or_legal", 32'(b_illegal_d), 32'd0);

        // lw latency E -> M -> W
        drive(7'b0000011, 3'b010, 1'b0);
        step();
        chk("lw_e", 32'({regwrite_e, resultsrc_e, alusrc_e}), 32'b1_01_1);
        drive(7'b0000000, 3'b000, 1'b0);
        step();
        chk("lw_m", 32'({regwrite_m, resultsrc_m}), 32'b1_01);
        step();
        chk("lw_w", 32'({regwrite_w, resultsrc_w}), 32'b1_01);

        // Branch / jump redirect
        drive(7'b1100011, 3'b000, 1'b0);
        step();
        zero_e = 1'b1;
        #1;
        chk("beq_taken", 32'(pcsrc_e), 32'd1);
        zero_e = 1'b0;
        #1;
        chk("beq_not_taken", 32'(pcsrc_e), 32'd0);
        drive(7'b1101111, 3'b000, 1'b0);
        step();
        chk("jal_pcsrc_z0", 32'(pcsrc_e), 32'd1);
        zero_e = 1'b1;
        #1;
        chk("jal_pcsrc_z1", 32'(pcsrc_e), 32'd1);
        zero_e = 1'b0;

        // sw held in E for two stalled clocks
        drive(7'b0100011, 3'b010, 1'b0);
        step();
        chk("sw_in_e", 32'(memwrite_e), 32'd1);
        drive(7'b0000000, 3'b000, 1'b0);
        stall_e = 1'b1;
        step();
        chk("stall1_e", 32'(memwrite_e), 32'd1);
        chk("stall1_m", 32'(memwrite_m), 32'd1);
        step();
        chk("stall2_e", 32'(memwrite_e), 32'd1);
        chk("stall2_m", 32'(memwrite_m), 32'd0);
        stall_e = 1'b0;
        step();
        chk("release_e", 32'(memwrite_e), 32'd0);
        chk("release_m", 32'(memwrite_m), 32'd0);

        // flush wins over stall
        drive(7'b0100011, 3'b010, 1'b0);
        step();
        stall_e = 1'b1;
        flush_e = 1'b1;
        step();
        chk("flush_stall_e", 32'(ex_bus()), 32'd0);
        stall_e = 1'b0;
        flush_e = 1'b0;

        // Illegal op stays a bubble all the way to W
        drive(7'b1111111, 3'b000, 1'b0);
        step();
        chk("ill_e", 32'({regwrite_e, memwrite_e, branch_e, jump_e}), 32'd0);
        step();
        chk("ill_m", 32'({regwrite_m, memwrite_m}), 32'd0);
        step();
        chk("ill_w", 32'(regwrite_w), 32'd0);

        // Asynchronous reset mid-cycle with regwrite_m set
        drive(7'b0110011, 3'b000, 1'b0);
        step();
        drive(7'b0000000, 3'b000, 1'b0);
        step();
        chk("pre_reset_rw_m", 32'(regwrite_m), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 32'(all_outs()), 32'd0);
        drive(7'b1101111, 3'b000, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_released_no_edge", 32'(all_outs()), 32'd0);
        step();
        chk("resume_jal_e", 32'({regwrite_e, jump_e, pcsrc_e}), 32'b111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
